// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float format constants, decode FSM states and float struct
package fp_pkg;

    localparam int FP_EW = 3;
    localparam int FP_FW = 4;
    localparam int FP_DW = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

    typedef struct packed {
        logic              s;
        logic [FP_EW-1:0]  e;
        logic [FP_FW-1:0]  f;
    } fp_t;

endpackage

// File: rtl/fp_dec_shifter.sv
// rtl/fp_dec_shifter.sv - magnitude shift/count datapath for fp_decode
// Optional FP_DEC_FASTSHIFT_EN: shift two bits per step while two or more remain.
module fp_dec_shifter
    import fp_pkg::*;
#(
    parameter int DW = FP_DW,
    parameter int EW = FP_EW,
    parameter int FW = FP_FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [EW-1:0] e,
    input  logic [FW-1:0] f,
    output logic [DW-1:0] mag,
    output logic          done
);

    logic [EW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
            cnt <= '0;
        end else if (load) begin
            mag <= {{(DW-FW){1'b0}}, f};
            cnt <= e;
        end else if (step && cnt != '0) begin
`ifdef FP_DEC_FASTSHIFT_EN
            if (cnt > EW'(1)) begin
                mag <= mag << 2;
                cnt <= cnt - EW'(2);
            end else begin
                mag <= mag << 1;
                cnt <= cnt - EW'(1);
            end
`else
            mag <= mag << 1;
            cnt <= cnt - EW'(1);
`endif
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fp_decode.sv
// rtl/fp_decode.sv - iterative float (S,E,F) to two's-complement linear decoder
// Optional FP_DEC_FASTSHIFT_EN (in fp_dec_shifter) halves the shift latency.
module fp_decode
    import fp_pkg::*;
#(
    parameter int DW = FP_DW,
    parameter int EW = FP_EW,
    parameter int FW = FP_FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          S,
    input  logic [EW-1:0] E,
    input  logic [FW-1:0] F,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] D
);

    // Largest magnitude plus a sign bit must fit in DW.
    if (DW < FW + (1 << EW)) begin : g_width_check
        $error("fp_decode: DW too small for FW + 2**EW");
    end

    state_t        state;
    state_t        state_nx;
    logic          sgn;
    logic          load;
    logic          step;
    logic          done;
    logic [DW-1:0] mag;

    fp_dec_shifter #(
        .DW(DW),
        .EW(EW),
        .FW(FW)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .e     (E),
        .f     (F),
        .mag   (mag),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn <= 1'b0;
            D   <= '0;
        end else begin
            if (load) begin
                sgn <= S;
            end
            // Negative zero negates to zero, so no special case is needed.
            if (state == SHIFT && done) begin
                D <= sgn ? -mag : mag;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (done) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_decode.sv
// tb/tb_fp_decode.sv - scoreboard bench for fp_decode with a reference model
module tb_fp_decode;

    localparam int DW = 12;
    localparam int EW = 3;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          S = 1'b0;
    logic [EW-1:0] E = '0;
    logic [FW-1:0] F = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] D;

    fp_decode #(.DW(DW), .EW(EW), .FW(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int sent   = 0;
    int outs   = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        int            acc;
        int            lat;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have = 1'b0;

    function automatic logic [DW-1:0] model(bit s, int e, int f);
        int v;
        v = f * (2 ** e);
        if (s) v = -v;
        return v[DW-1:0];
    endfunction

    function automatic int lat_of(int e);
`ifdef FP_DEC_FASTSHIFT_EN
        return (e + 1) / 2 + 1;
`else
        return e + 1;
`endif
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard: expectations pushed on acceptance, popped and compared on output.
    always @(negedge clk) begin
        if (!rst_n) begin
            have = 1'b0;
        end else begin
            if (in_valid && in_ready)
                q.push_back('{model(S, int'(E), int'(F)), cyc + 1, lat_of(int'(E))});
            if (out_valid) begin
                if (!have) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", 1, 0);
                    end else begin
                        cur  = q.pop_front();
                        have = 1'b1;
                        chk("D", int'(D), int'(cur.d));
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end else begin
                    chk("D_stable", int'(D), int'(cur.d));
                end
                chk("in_ready_in_out", int'(in_ready), 0);
                if (out_ready) begin
                    have = 1'b0;
                    outs++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(bit s, int e, int f, bit scramble);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        S = s;
        E = e[EW-1:0];
        F = f[FW-1:0];
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        sent++;
        if (scramble) begin
            for (int k = 0; k < 4; k++) begin
                S = 1'($urandom);
                E = EW'($urandom);
                F = FW'($urandom);
                @(negedge clk);
                chk("in_ready_busy", int'(in_ready), 0);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400; n++) begin
            if (outs == sent) return;
            @(negedge clk);
        end
        chk("drain_timeout", outs, sent);
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_D", int'(D), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(0, 1, 4'b1000, 0);
        wait_done();
        send(0, 7, 4'b1111, 0);
        wait_done();
        send(1, 7, 4'b1111, 0);
        send(1, 3, 4'b0000, 0);
        send(0, 2, 4'b0011, 0);
        send(1, 0, 4'b1001, 0);
        wait_done();

        send(0, 7, 4'b0101, 1);
        wait_done();

        // Backpressure
        out_ready = 1'b0;
        send(1, 5, 4'b1001, 0);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_rise", int'(seen), 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid_held", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        wait_done();

        // Reset in the middle of a long shift
        send(0, 7, 4'b1111, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_D", int'(D), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        q.delete();
        sent = outs;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(0, 4, 4'b1011, 0);
        wait_done();

        rand_rdy = 1'b1;
        repeat (40) begin
            send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 0);
        end
        wait_done();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_done();

        chk("scoreboard_empty", q.size(), 0);
        chk("outputs_vs_sent", outs, sent);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
